// File: rtl/snac_pad_pkg.sv
// Shared types and default timing for the SNAC serial gamepad poller.
package snac_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  // Defaults assume a 28.375160 MHz system clock.
  localparam int DEF_POLL_CYC  = 472919;
  localparam int DEF_LATCH_CYC = 340;
  localparam int DEF_HALF_CYC  = 170;

  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pad_data_sync.sv
// Two-flop synchronizer for the asynchronous pad data line; resets to the released level.
module pad_data_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/snac_pad_poller.sv
// Periodically latches and clocks an NES/SNES pad, publishing active-high button levels
// with a one-cycle valid strobe after every completed scan.
module snac_pad_poller
  import snac_pad_pkg::*;
#(
  parameter int POLL_CYC  = DEF_POLL_CYC,
  parameter int LATCH_CYC = DEF_LATCH_CYC,
  parameter int HALF_CYC  = DEF_HALF_CYC,
  parameter int NUM_BITS  = SNES_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pad_data,
  output logic                pad_latch,
  output logic                pad_clk,
  output logic [NUM_BITS-1:0] buttons,
  output logic                buttons_valid,
  output logic                busy
);

  localparam int PW  = $clog2(POLL_CYC);
  localparam int PHW = $clog2(max_int(LATCH_CYC, HALF_CYC));
  localparam int BW  = $clog2(NUM_BITS);

  localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_CYC - 1);
  localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_CYC - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_CYC - 1);
  localparam logic [BW-1:0]  BIT_LAST   = BW'(NUM_BITS - 1);

  state_t              state;
  logic [PW-1:0]       poll_cnt;
  logic [PHW-1:0]      phase;
  logic [BW-1:0]       bit_idx;
  logic [NUM_BITS-1:0] shift_reg;
  logic                pad_data_sync_q;
  logic                tick;

  pad_data_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pad_data),
    .sync_out (pad_data_sync_q)
  );

  // The poll counter runs regardless of state so the poll rate never drifts with scans.
  always_ff @(posedge clk) begin
    if (reset || poll_cnt == POLL_LAST) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign tick = (poll_cnt == POLL_LAST);

  // Outputs are set on the transition into each state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      phase         <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      pad_latch     <= 1'b0;
      pad_clk       <= 1'b1;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      buttons_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && enable) begin
            state     <= LATCH;
            phase     <= '0;
            pad_latch <= 1'b1;
            pad_clk   <= 1'b1;
            busy      <= 1'b1;
          end
        end

        LATCH: begin
          if (phase == LATCH_LAST) begin
            state     <= LOW;
            phase     <= '0;
            bit_idx   <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        // Sampling late in the low half gives the pad the whole half-period to settle.
        LOW: begin
          if (phase == HALF_LAST) begin
            shift_reg[bit_idx] <= ~pad_data_sync_q;
            state              <= HIGH;
            phase              <= '0;
            pad_clk            <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        HIGH: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            if (bit_idx == BIT_LAST) begin
              state         <= DONE;
              buttons       <= shift_reg;
              buttons_valid <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              state   <= LOW;
              pad_clk <= 1'b0;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          pad_latch <= 1'b0;
          pad_clk   <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
